// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for sequencer state and interrupt register selection
package cpu_pkg;
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] HALT = 2'd1;
  localparam logic [1:0] DISPATCH = 2'd2;
  localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'h0040;
  localparam logic IE_SEL = 1'b0;
  localparam logic IF_SEL = 1'b1;
endpackage

// File: rtl/interrupt_dispatcher_priority_encoder.sv
// priority_encoder: lowest-set-bit one-hot, its index, and an any-bit-set flag
module priority_encoder #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_In,
  output logic [WIDTH-1:0] o_One_Hot,
  output logic [IW-1:0]    o_Index,
  output logic             o_Valid
);
  assign o_One_Hot = i_In & (~i_In + WIDTH'(1));
  assign o_Valid = |i_In;
  always_comb begin
    o_Index = '0;
    for (int k = WIDTH - 1; k >= 0; k--)
      if (i_In[k]) o_Index = IW'(k);
  end
endmodule

// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: IE/IF/IME interrupt controller with EI delay, HALT wake-up and vectored dispatch
module interrupt_dispatcher
  import cpu_pkg::*;
#(
  parameter int          NUM_SOURCES   = 5,
  parameter logic [15:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Enable,
  input  logic [NUM_SOURCES-1:0] i_Request,
  input  logic                   i_Reg_Sel,
  input  logic                   i_Reg_Write,
  input  logic [7:0]             i_Data,
  output logic [7:0]             o_Data,
  input  logic                   i_Boundary,
  input  logic                   i_EI,
  input  logic                   i_DI,
  input  logic                   i_RETI,
  input  logic                   i_Halt,
  input  logic                   i_Ack,
  output logic                   o_Handle_Interrupt,
  output logic [15:0]            o_Vector,
  output logic                   o_Halted,
  output logic                   o_IME
);
  localparam int N = NUM_SOURCES;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] STRIDE = 16'(VECTOR_STRIDE);
  if (NUM_SOURCES < 1 || NUM_SOURCES > 8) begin : g_bad_num_sources
    $error("interrupt_dispatcher: NUM_SOURCES must be in 1..8");
  end
  logic [1:0]    r_state;
  logic [N-1:0]  r_ie;
  logic [N-1:0]  r_if;
  logic [N-1:0]  r_mask;
  logic [IW-1:0] r_idx;
  logic          r_ime;
  logic          r_ei;
  logic [N-1:0]  w_pending;
  logic [N-1:0]  w_onehot;
  logic [IW-1:0] w_idx;
  logic          w_valid;
  logic [1:0]    w_state_next;
  logic          w_enter;
  logic          w_ack_clr;
  logic [N-1:0]  w_ie_next;
  logic [N-1:0]  w_if_next;
  logic [7:0]    w_data;
  logic          w_unused;
  assign w_unused = ^i_Data;
  assign w_pending = r_ie & r_if;
  priority_encoder #(.WIDTH(N)) u_pe (
    .i_In      (w_pending),
    .o_One_Hot (w_onehot),
    .o_Index   (w_idx),
    .o_Valid   (w_valid)
  );
  always_comb begin
    w_state_next = r_state;
    w_enter = 1'b0;
    case (r_state)
      RUN: begin
        w_enter = i_Boundary && r_ime && w_valid;
        w_state_next = w_enter ? DISPATCH : i_Halt ? HALT : RUN;
      end
      HALT: begin
        w_enter = w_valid && r_ime;
        w_state_next = !w_valid ? HALT : r_ime ? DISPATCH : RUN;
      end
      DISPATCH: w_state_next = i_Ack ? RUN : DISPATCH;
      default: w_state_next = RUN;
    endcase
  end
  // request beats the dispatch clear, which beats a register write
  assign w_ack_clr = (r_state == DISPATCH) && i_Ack;
  assign w_ie_next = (i_Reg_Write && i_Reg_Sel == IE_SEL) ? i_Data[N-1:0] : r_ie;
  assign w_if_next = (((i_Reg_Write && i_Reg_Sel == IF_SEL) ? i_Data[N-1:0] : r_if)
                      & ~(w_ack_clr ? r_mask : '0)) | i_Request;
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= RUN;
      r_ie <= '0;
      r_if <= '0;
      r_mask <= '0;
      r_idx <= '0;
      r_ime <= 1'b0;
      r_ei <= 1'b0;
    end else if (i_Enable) begin
      r_state <= w_state_next;
      r_ie <= w_ie_next;
      r_if <= w_if_next;
      r_ime <= w_enter ? 1'b0 : i_DI ? 1'b0 : i_RETI ? 1'b1 : (i_Boundary && r_ei) ? 1'b1 : r_ime;
      r_ei <= i_DI ? 1'b0 : i_EI ? 1'b1 : (i_Boundary && r_ei) ? 1'b0 : r_ei;
      if (w_enter) begin
        r_idx <= w_idx;
        r_mask <= w_onehot;
      end
    end
  end
  always_comb begin
    w_data = 8'hFF;
    w_data[N-1:0] = (i_Reg_Sel == IF_SEL) ? r_if : r_ie;
  end
  assign o_Data = w_data;
  assign o_Handle_Interrupt = r_state == DISPATCH;
  assign o_Vector = (r_state == DISPATCH) ? VECTOR_BASE + 16'(r_idx) * STRIDE : 16'h0000;
  assign o_Halted = r_state == HALT;
  assign o_IME = r_ime;
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb_interrupt_dispatcher: vector table, hand sequences and randomized run against a behavioural model
module tb_interrupt_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b1, sel = 1'b0, wr = 1'b0, bnd = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0, halt = 1'b0, ack = 1'b0;
  logic [7:0] req = 8'h00, dat = 8'h00;
  logic hi5, hlt5, ime5, hi8, hlt8, ime8;
  logic [15:0] vec5, vec8;
  logic [7:0] od5, od8;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [5:0] SB = 6'd1, SE = 6'd2, SD = 6'd4, SR = 6'd8, SH = 6'd16, SA = 6'd32;
  always #5 clk = ~clk;

  interrupt_dispatcher dut5 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Request(req[4:0]),
    .i_Reg_Sel(sel), .i_Reg_Write(wr), .i_Data(dat), .o_Data(od5),
    .i_Boundary(bnd), .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Halt(halt), .i_Ack(ack),
    .o_Handle_Interrupt(hi5), .o_Vector(vec5), .o_Halted(hlt5), .o_IME(ime5)
  );
  interrupt_dispatcher #(.NUM_SOURCES(8), .VECTOR_BASE(16'hFFF8), .VECTOR_STRIDE(8)) dut8 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Request(req),
    .i_Reg_Sel(sel), .i_Reg_Write(wr), .i_Data(dat), .o_Data(od8),
    .i_Boundary(bnd), .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Halt(halt), .i_Ack(ack),
    .o_Handle_Interrupt(hi8), .o_Vector(vec8), .o_Halted(hlt8), .o_IME(ime8)
  );

  // behavioural model of the 5-source instance: mode 0=running 1=halted 2=dispatching
  int m_ie, m_if, m_mode, m_idx;
  bit m_ime, m_ei;

  task automatic model_reset();
    m_ie = 0; m_if = 0; m_mode = 0; m_idx = 0; m_ime = 0; m_ei = 0;
  endtask

  task automatic model_step(input int rq, input bit s, input bit w, input int d, input logic [5:0] st, input bit e);
    int pend, lo, nif;
    bit go, b, a;
    if (!e) return;
    b = st[0]; a = st[5];
    pend = m_ie & m_if;
    lo = -1;
    for (int i = 0; i < 5; i++) if (lo < 0 && ((pend >> i) & 1) == 1) lo = i;
    nif = (w && s) ? (d & 31) : m_if;
    if (m_mode == 2 && a) nif = nif & ~(1 << m_idx);
    nif = nif | (rq & 31);
    go = 0;
    if (m_mode == 0) begin
      if (b && m_ime && pend != 0) begin go = 1; m_mode = 2; m_idx = lo; end
      else if (st[4]) m_mode = 1;
    end else if (m_mode == 1) begin
      if (pend != 0) begin
        if (m_ime) begin go = 1; m_mode = 2; m_idx = lo; end
        else m_mode = 0;
      end
    end else if (a) m_mode = 0;
    if (w && !s) m_ie = d & 31;
    m_if = nif;
    if (go || st[2]) m_ime = 0;
    else if (st[3] || (b && m_ei)) m_ime = 1;
    if (st[2]) m_ei = 0;
    else if (st[1]) m_ei = 1;
    else if (b) m_ei = 0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] rq, input logic s, input logic w, input logic [7:0] d,
                       input logic [5:0] st, input logic e);
    req = rq; sel = s; wr = w; dat = d; en = e;
    {ack, halt, reti, di, ei, bnd} = st;
    model_step(int'(rq), s, w, int'(d), st, e);
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    req = 0; wr = 0; dat = 0; en = 1; {ack, halt, reti, di, ei, bnd} = 6'd0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rq; logic s, w; logic [7:0] d; logic [5:0] st; logic e;
    logic hi; logic [15:0] v; logic hl, im; logic [7:0] od;
  } row_t;

  function automatic row_t mk(logic [4:0] rq, logic s, logic w, logic [7:0] d, logic [5:0] st, logic e,
                              logic hi, logic [15:0] v, logic hl, logic im, logic [7:0] od);
    row_t r;
    r.rq = rq; r.s = s; r.w = w; r.d = d; r.st = st; r.e = e;
    r.hi = hi; r.v = v; r.hl = hl; r.im = im; r.od = od;
    return r;
  endfunction

  initial begin
    row_t rows[$];
    rows.push_back(mk(5'h00, 0, 1, 8'h1F, 0,       1, 0, 16'h0000, 0, 0, 8'hFF));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SR,      1, 0, 16'h0000, 0, 1, 8'hE0));
    rows.push_back(mk(5'h14, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 0, 1, 8'hF4));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 1, 16'h0050, 0, 0, 8'hF4));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, 0,       1, 1, 16'h0050, 0, 0, 8'hF4));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SA,      1, 0, 16'h0000, 0, 0, 8'hF0));
    rows.push_back(mk(5'h00, 1, 1, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE0));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SE,      1, 0, 16'h0000, 0, 0, 8'hE0));
    rows.push_back(mk(5'h01, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 0, 16'h0000, 0, 1, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 1, 16'h0040, 0, 0, 8'hE1));
    rows.push_back(mk(5'h01, 1, 0, 8'h00, SA,      1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h08, 1, 1, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SE,      1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SD,      1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 1, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE0));
    rows.push_back(mk(5'h00, 0, 1, 8'h08, 0,       1, 0, 16'h0000, 0, 0, 8'hE8));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SH,      1, 0, 16'h0000, 1, 0, 8'hE0));
    rows.push_back(mk(5'h01, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 1, 0, 8'hE1));
    rows.push_back(mk(5'h08, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 1, 0, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE9));
    rows.push_back(mk(5'h02, 1, 1, 8'h00, SH,      0, 0, 16'h0000, 0, 0, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SH,      1, 0, 16'h0000, 1, 0, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, 0,       1, 0, 16'h0000, 0, 0, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SR,      1, 0, 16'h0000, 0, 1, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SH,      1, 0, 16'h0000, 1, 1, 8'hE9));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, 0,       1, 1, 16'h0058, 0, 0, 8'hE9));
    rows.push_back(mk(5'h00, 0, 1, 8'h00, 0,       1, 1, 16'h0058, 0, 0, 8'hE0));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SA,      1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SE | SD, 1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SB,      1, 0, 16'h0000, 0, 0, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SR,      1, 0, 16'h0000, 0, 1, 8'hE1));
    rows.push_back(mk(5'h00, 1, 0, 8'h00, SD,      1, 0, 16'h0000, 0, 0, 8'hE1));

    // registers loaded before the first reset must not survive it
    drive(8'h00, 0, 1, 8'h1F, 0, 1);
    drive(8'h00, 1, 1, 8'h1F, 0, 1);
    check("pre_reset_if", od5, 8'hFF);
    sel = 1'b1;
    assert_reset();
    check("in_reset_outs", {hi5, vec5, hlt5, ime5, od5}, {1'b0, 16'h0000, 1'b0, 1'b0, 8'hE0});
    sel = 1'b0;
    #1 check("in_reset_ie", od5, 8'hE0);
    release_reset();
    check("after_reset_outs", {hi5, vec5, hlt5, ime5, od5}, {1'b0, 16'h0000, 1'b0, 1'b0, 8'hE0});

    foreach (rows[i]) begin
      drive({3'b000, rows[i].rq}, rows[i].s, rows[i].w, rows[i].d, rows[i].st, rows[i].e);
      check($sformatf("row%0d", i), {hi5, vec5, hlt5, ime5, od5},
            {rows[i].hi, rows[i].v, rows[i].hl, rows[i].im, rows[i].od});
    end

    // reset in the middle of a dispatch and in the middle of a halt
    drive(8'h00, 0, 1, 8'h01, 0, 1);
    drive(8'h00, 1, 0, 8'h00, SR, 1);
    drive(8'h00, 1, 0, 8'h00, SB, 1);
    check("dispatch_before_reset", {hi5, vec5}, {1'b1, 16'h0040});
    assert_reset();
    check("reset_mid_dispatch", {hi5, vec5, hlt5, ime5, od5}, {1'b0, 16'h0000, 1'b0, 1'b0, 8'hE0});
    release_reset();
    drive(8'h00, 1, 0, 8'h00, SH, 1);
    check("halt_before_reset", hlt5, 1'b1);
    assert_reset();
    check("reset_mid_halt", {hi5, hlt5, ime5}, 3'b000);
    release_reset();

    for (int c = 0; c < 600; c++) begin
      logic [5:0] st;
      st = {($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 23) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0)};
      drive(($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 31)) : 8'h00, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0), 8'($urandom_range(0, 255)), st, ($urandom_range(0, 9) != 0));
      check($sformatf("rand%0d", c), {hi5, vec5, hlt5, ime5, od5},
            {m_mode == 2, (m_mode == 2) ? 16'(64 + 8 * m_idx) : 16'h0000, m_mode == 1, m_ime,
             8'(32'hE0 | (sel ? m_if : m_ie))});
    end

    // eight sources, vector base near the top of memory
    assert_reset();
    release_reset();
    drive(8'h00, 0, 1, 8'hF8, 0, 1);
    check("n8_ie_upper_bits", od8, 8'hF8);
    drive(8'h08, 1, 0, 8'h00, 0, 1);
    check("n8_if_read", od8, 8'h08);
    drive(8'h00, 1, 0, 8'h00, SR, 1);
    drive(8'h00, 1, 0, 8'h00, SB, 1);
    check("n8_vector_wrap", {hi8, vec8, ime8, hlt8}, {1'b1, 16'h0010, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
